// File: rtl/vproc_div_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vproc_div_iter_if : handshake/operand bundle for the iterative divider   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface vproc_div_iter_if #(
  parameter int unsigned DIV_OP_W = 64,
  parameter int unsigned CTRL_W   = 32
);
  logic                  pipe_in_valid_i;
  logic                  pipe_in_ready_o;
  logic [CTRL_W-1:0]     pipe_in_ctrl_i;
  logic [1:0]            pipe_in_eew_i;
  logic                  pipe_in_rem_i;
  logic                  pipe_in_signed_i;
  logic [DIV_OP_W-1:0]   pipe_in_op1_i;
  logic [DIV_OP_W-1:0]   pipe_in_op2_i;
  logic [DIV_OP_W/8-1:0] pipe_in_mask_i;
  logic                  pipe_out_valid_o;
  logic                  pipe_out_ready_i;
  logic [CTRL_W-1:0]     pipe_out_ctrl_o;
  logic [DIV_OP_W-1:0]   pipe_out_res_o;
  logic [DIV_OP_W/8-1:0] pipe_out_mask_o;

  modport slave (
    input  pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_eew_i, pipe_in_rem_i, pipe_in_signed_i,
    input  pipe_in_op1_i, pipe_in_op2_i, pipe_in_mask_i, pipe_out_ready_i,
    output pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o, pipe_out_res_o, pipe_out_mask_o
  );

  modport master (
    output pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_eew_i, pipe_in_rem_i, pipe_in_signed_i,
    output pipe_in_op1_i, pipe_in_op2_i, pipe_in_mask_i, pipe_out_ready_i,
    input  pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o, pipe_out_res_o, pipe_out_mask_o
  );
endinterface
`default_nettype wire

// File: rtl/vproc_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vproc_div_iter : iterative SIMD restoring divider, SEW 8/16/32/64        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vproc_div_iter #(
  parameter int unsigned DIV_OP_W       = 64,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned CTRL_W         = 32
) (
  input  logic            clk_i,
  input  logic            sync_rst_ni,
  vproc_div_iter_if.slave pipe
);
  localparam int unsigned NB = DIV_OP_W / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [DIV_OP_W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [NB-1:0]       mask_q, mask_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [1:0]          eew_q, eew_d;
  logic                rem_q, rem_d, sgn_q, sgn_d;

  logic [6:0]          w_sew, w_n_iter;
  logic [63:0]         w_emask;
  logic                w_in_ready, w_in_hs;
  logic [DIV_OP_W-1:0] w_res_raw, w_res;

  function automatic logic sign_bit(input logic [63:0] x, input logic [1:0] eew);
    case (eew)
      2'd0:    return x[7];
      2'd1:    return x[15];
      2'd2:    return x[31];
      default: return x[63];
    endcase
  endfunction

  assign w_sew    = 7'd8 << eew_q;
  assign w_n_iter = w_sew >> $clog2(BITS_PER_CYCLE);

  always_comb begin
    case (eew_q)
      2'd0:    w_emask = 64'h0000_0000_0000_00FF;
      2'd1:    w_emask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_emask = 64'h0000_0000_FFFF_FFFF;
      default: w_emask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign w_in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & pipe.pipe_out_ready_i);
  assign w_in_hs    = pipe.pipe_in_valid_i & w_in_ready;

  // Each element lives in its own 64-bit container, so no carry can cross elements.
  for (genvar i = 0; i < NB; i++) begin : g_elem
    logic [63:0]         a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
    logic                neg_q, neg_d, dz_q, dz_d, ov_q, ov_d;
    logic [DIV_OP_W-1:0] w_sh1, w_sh2, w_part, w_acc;
    logic [63:0]         w_x1, w_x2, w_abs1, w_abs2, w_qv, w_rv, w_val;
    logic [63:0]         a_t, q_t, r_t;
    logic [64:0]         r_sh;
    logic                w_s1, w_s2, w_act;

    assign w_sh1  = op1_q >> (i * w_sew);
    assign w_sh2  = op2_q >> (i * w_sew);
    assign w_x1   = w_sh1[63:0] & w_emask;
    assign w_x2   = w_sh2[63:0] & w_emask;
    assign w_s1   = sign_bit(w_x1, eew_q);
    assign w_s2   = sign_bit(w_x2, eew_q);
    assign w_abs1 = (sgn_q & w_s1) ? ((64'd0 - w_x1) & w_emask) : w_x1;
    assign w_abs2 = (sgn_q & w_s2) ? ((64'd0 - w_x2) & w_emask) : w_x2;
    assign w_act  = (i * w_sew) < DIV_OP_W;

    always_comb begin
      a_t  = a_q;
      q_t  = q_q;
      r_t  = r_q;
      r_sh = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
        r_sh = {r_t, a_t[63]};
        a_t  = {a_t[62:0], 1'b0};
        if (r_sh >= {1'b0, b_q}) begin
          r_sh = r_sh - {1'b0, b_q};
          q_t  = {q_t[62:0], 1'b1};
        end else begin
          q_t  = {q_t[62:0], 1'b0};
        end
        r_t = r_sh[63:0];
      end
    end

    always_comb begin
      a_d = a_q; b_d = b_q; q_d = q_q; r_d = r_q;
      neg_d = neg_q; dz_d = dz_q; ov_d = ov_q;
      case (state_q)
        ST_PREP: begin
          // Dividend is left-aligned so its next bit is always bit 63.
          a_d   = w_abs1 << (7'd64 - w_sew);
          b_d   = w_abs2;
          q_d   = '0;
          r_d   = '0;
          neg_d = sgn_q & (rem_q ? w_s1 : (w_s1 ^ w_s2));
          dz_d  = (w_x2 == 64'd0);
          ov_d  = sgn_q & (w_x1 == (w_emask ^ (w_emask >> 1))) & (w_x2 == w_emask);
        end
        ST_ITER: begin
          a_d = a_t;
          q_d = q_t;
          r_d = r_t;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_i) begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      r_q   <= r_d;
      neg_q <= neg_d;
      dz_q  <= dz_d;
      ov_q  <= ov_d;
    end

    assign w_qv  = (neg_q ? (64'd0 - q_q) : q_q) & w_emask;
    assign w_rv  = (neg_q ? (64'd0 - r_q) : r_q) & w_emask;
    assign w_val = dz_q ? (rem_q ? w_x1 : w_emask) :
                   ov_q ? (rem_q ? 64'd0 : w_x1) :
                   (rem_q ? w_rv : w_qv);
    assign w_part = w_act ? (DIV_OP_W'(w_val) << (i * w_sew)) : '0;

    if (i == 0) begin : g_first
      assign w_acc = w_part;
    end else begin : g_chain
      assign w_acc = g_elem[i-1].w_acc | w_part;
    end
  end

  assign w_res_raw = g_elem[NB-1].w_acc;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign w_res[b*8 +: 8] = mask_q[b] ? w_res_raw[b*8 +: 8] : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    mask_d  = mask_q;
    ctrl_d  = ctrl_q;
    eew_d   = eew_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    case (state_q)
      ST_IDLE: if (w_in_hs) state_d = ST_PREP;
      ST_PREP: begin
        state_d = ST_ITER;
        cnt_d   = 6'(w_n_iter - 7'd1);
      end
      ST_ITER: begin
        if (cnt_q == 6'd0) state_d = ST_FIX;
        else               cnt_d   = cnt_q - 6'd1;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        res_d   = w_res;
      end
      ST_DONE: if (pipe.pipe_out_ready_i) state_d = w_in_hs ? ST_PREP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (w_in_hs) begin
      op1_d  = pipe.pipe_in_op1_i;
      op2_d  = pipe.pipe_in_op2_i;
      mask_d = pipe.pipe_in_mask_i;
      ctrl_d = pipe.pipe_in_ctrl_i;
      eew_d  = pipe.pipe_in_eew_i;
      rem_d  = pipe.pipe_in_rem_i;
      sgn_d  = pipe.pipe_in_signed_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      mask_q  <= '0;
      ctrl_q  <= '0;
      eew_q   <= '0;
      rem_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      eew_q   <= eew_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
    end
  end

  assign pipe.pipe_in_ready_o  = w_in_ready;
  assign pipe.pipe_out_valid_o = (state_q == ST_DONE);
  assign pipe.pipe_out_res_o   = res_q;
  assign pipe.pipe_out_mask_o  = mask_q;
  assign pipe.pipe_out_ctrl_o  = ctrl_q;
endmodule
`default_nettype wire

// File: tb/tb_vproc_div_iter.sv
`default_nettype none
// Bench for vproc_div_iter: three instances (1/2/4 bits per cycle) checked
// against a plain-arithmetic RISC-V division model.
module tb_vproc_div_iter;
  localparam int W  = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    in_valid = 3'b000;
  logic          out_ready = 1'b1;
  logic [CW-1:0] ctrl = '0;
  logic [1:0]    eew = '0;
  logic          rem = 1'b0, sgn = 1'b0;
  logic [W-1:0]  op1 = '0, op2 = '0;
  logic [7:0]    mask = '0;

  logic [2:0]    in_ready, out_valid;
  logic [W-1:0]  res    [3];
  logic [7:0]    mask_o [3];
  logic [CW-1:0] ctrl_o [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    vproc_div_iter_if #(.DIV_OP_W(W), .CTRL_W(CW)) u_if ();
    assign u_if.pipe_in_valid_i  = in_valid[k];
    assign u_if.pipe_in_ctrl_i   = ctrl;
    assign u_if.pipe_in_eew_i    = eew;
    assign u_if.pipe_in_rem_i    = rem;
    assign u_if.pipe_in_signed_i = sgn;
    assign u_if.pipe_in_op1_i    = op1;
    assign u_if.pipe_in_op2_i    = op2;
    assign u_if.pipe_in_mask_i   = mask;
    assign u_if.pipe_out_ready_i = out_ready;
    assign in_ready[k]  = u_if.pipe_in_ready_o;
    assign out_valid[k] = u_if.pipe_out_valid_o;
    assign res[k]       = u_if.pipe_out_res_o;
    assign mask_o[k]    = u_if.pipe_out_mask_o;
    assign ctrl_o[k]    = u_if.pipe_out_ctrl_o;

    vproc_div_iter #(.DIV_OP_W(W), .BITS_PER_CYCLE(1 << k), .CTRL_W(CW)) u_dut (
      .clk_i       (clk),
      .sync_rst_ni (rst_n),
      .pipe        (u_if.slave)
    );
  end

  // Reference: one element, RISC-V semantics, plain arithmetic.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input int sew, input logic r, input logic s);
    logic [63:0] m, t;
    longint sa, sb, lmin;
    m = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    if (b == 64'd0) return r ? a : m;
    if (s) begin
      t  = a << (64 - sew);
      sa = $signed(t) >>> (64 - sew);
      t  = b << (64 - sew);
      sb = $signed(t) >>> (64 - sew);
      lmin = longint'(64'd1 << (sew - 1));
      lmin = -lmin;
      if (sb == -64'sd1 && sa == lmin) return r ? 64'd0 : a;
      return m & (r ? 64'(sa % sb) : 64'(sa / sb));
    end
    return m & (r ? (a % b) : (a / b));
  endfunction

  function automatic logic [63:0] ref_pack(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] e, input logic r, input logic s,
                                           input logic [7:0] mk);
    int sew;
    logic [63:0] m, o, v;
    sew = 8 << e;
    m = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    o = '0;
    for (int i = 0; i < 64 / sew; i++) begin
      v = ref_div((a >> (i * sew)) & m, (b >> (i * sew)) & m, sew, r, s);
      o = o | (v << (i * sew));
    end
    for (int j = 0; j < 8; j++) if (!mk[j]) o[j*8 +: 8] = 8'h00;
    return o;
  endfunction

  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] e, input logic r, input logic s,
                        input logic [7:0] mk, input logic [31:0] c,
                        output logic [63:0] got, output int lat);
    int w;
    @(negedge clk);
    op1 = a; op2 = b; eew = e; rem = r; sgn = s; mask = mk; ctrl = c;
    in_valid[k] = 1'b1;
    w = 0;
    while (!in_ready[k] && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 200) begin @(negedge clk); lat++; end
    got = res[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready[k] !== 1'b1) begin n_err++; $display("FAIL rst_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_err++; $display("FAIL rst_valid[%0d]: got %b want 0", k, out_valid[k]); end
      n_cmp++; if (res[k] !== 64'd0) begin n_err++; $display("FAIL rst_res[%0d]: got %h want 0", k, res[k]); end
      n_cmp++; if (mask_o[k] !== 8'd0 || ctrl_o[k] !== 32'd0) begin n_err++; $display("FAIL rst_mask_ctrl[%0d]: got %h/%h want 0/0", k, mask_o[k], ctrl_o[k]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned8();
    logic [63:0] got; int lat;
    run_op(0, {8{8'd200}}, {8{8'd7}}, 2'd0, 1'b0, 1'b0, 8'hFF, 32'hA5A5_0001, got, lat);
    n_cmp++; if (got !== {8{8'd28}}) begin n_err++; $display("FAIL u8_quot: got %h want %h", got, {8{8'd28}}); end
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL u8_latency: got %0d want 10", lat); end
    n_cmp++; if (ctrl_o[0] !== 32'hA5A5_0001) begin n_err++; $display("FAIL u8_ctrl: got %h want a5a50001", ctrl_o[0]); end
    run_op(0, {8{8'd200}}, {8{8'd7}}, 2'd0, 1'b1, 1'b0, 8'hFF, 32'h2, got, lat);
    n_cmp++; if (got !== {8{8'd4}}) begin n_err++; $display("FAIL u8_rem: got %h want %h", got, {8{8'd4}}); end
  endtask

  task automatic test_signed32();
    logic [63:0] got; int lat;
    run_op(0, 64'hFFFF_FFF9_0000_0007, 64'h0000_0002_FFFF_FFFE, 2'd2, 1'b0, 1'b1, 8'hFF, 32'h3, got, lat);
    n_cmp++; if (got !== 64'hFFFF_FFFD_FFFF_FFFD) begin n_err++; $display("FAIL s32_quot: got %h want fffffffdfffffffd", got); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL s32_latency: got %0d want 34", lat); end
    run_op(0, 64'hFFFF_FFF9_0000_0007, 64'h0000_0002_FFFF_FFFE, 2'd2, 1'b1, 1'b1, 8'hFF, 32'h4, got, lat);
    n_cmp++; if (got !== 64'hFFFF_FFFF_0000_0001) begin n_err++; $display("FAIL s32_rem: got %h want ffffffff00000001", got); end
  endtask

  task automatic test_special16();
    logic [63:0] got; int lat;
    run_op(0, 64'h0005_1234_1234_8000, 64'h0002_0000_0000_FFFF, 2'd1, 1'b0, 1'b1, 8'hFF, 32'h5, got, lat);
    n_cmp++; if (got !== 64'h0002_FFFF_FFFF_8000) begin n_err++; $display("FAIL s16_quot: got %h want 0002ffffffff8000", got); end
    run_op(0, 64'h0005_1234_1234_8000, 64'h0002_0000_0000_FFFF, 2'd1, 1'b1, 1'b1, 8'hFF, 32'h6, got, lat);
    n_cmp++; if (got !== 64'h0001_1234_1234_0000) begin n_err++; $display("FAIL s16_rem: got %h want 0001123412340000", got); end
    run_op(0, 64'h0005_1234_1234_8000, 64'h0002_0000_0000_FFFF, 2'd1, 1'b0, 1'b0, 8'hFF, 32'h7, got, lat);
    n_cmp++; if (got !== 64'h0002_FFFF_FFFF_0000) begin n_err++; $display("FAIL u16_quot: got %h want 0002ffffffff0000", got); end
  endtask

  task automatic test_sew64_latency();
    logic [63:0] got; int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(k, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'd3, 1'b0, 1'b0, 8'hFF, 32'h8, got, lat);
      n_cmp++; if (got !== 64'h5555_5555_5555_5555) begin n_err++; $display("FAIL u64_quot[%0d]: got %h want 5555555555555555", k, got); end
      n_cmp++; if (lat !== 64 / (1 << k) + 2) begin n_err++; $display("FAIL u64_latency[%0d]: got %0d want %0d", k, lat, 64 / (1 << k) + 2); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, snap, a2, b2, exp2; int lat;
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom} | 64'h0101_0101_0101_0101;
    out_ready = 1'b0;
    run_op(0, 64'hFFEE_DDCC_BBAA_9988, 64'h0703_0509_0B0D_0211, 2'd0, 1'b0, 1'b0, 8'hFF, 32'hBEEF, got, lat);
    n_cmp++; if (got !== ref_pack(64'hFFEE_DDCC_BBAA_9988, 64'h0703_0509_0B0D_0211, 2'd0, 1'b0, 1'b0, 8'hFF)) begin n_err++; $display("FAIL bp_first: got %h", got); end
    snap = got;
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (out_valid[0] !== 1'b1 || res[0] !== snap || ctrl_o[0] !== 32'hBEEF) begin n_err++; $display("FAIL bp_stable: valid %b res %h want 1 %h", out_valid[0], res[0], snap); end
      n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready[0]); end
    end
    op1 = a2; op2 = b2; eew = 2'd0; rem = 1'b1; sgn = 1'b1; mask = 8'hFF; ctrl = 32'hCAFE;
    in_valid[0] = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready[0]); end
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL b2b_accept: valid %b want 0", out_valid[0]); end
    lat = 0;
    while (!out_valid[0] && lat < 200) begin @(negedge clk); lat++; end
    exp2 = ref_pack(a2, b2, 2'd0, 1'b1, 1'b1, 8'hFF);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL b2b_latency: got %0d want 10", lat); end
    n_cmp++; if (res[0] !== exp2 || ctrl_o[0] !== 32'hCAFE) begin n_err++; $display("FAIL b2b_res: got %h want %h", res[0], exp2); end
  endtask

  task automatic test_mask();
    logic [63:0] got; int lat;
    run_op(0, {8{8'd200}}, {8{8'd7}}, 2'd0, 1'b0, 1'b0, 8'h0F, 32'h9, got, lat);
    n_cmp++; if (got !== 64'h0000_0000_1C1C_1C1C) begin n_err++; $display("FAIL mask_res: got %h want 000000001c1c1c1c", got); end
    n_cmp++; if (mask_o[0] !== 8'h0F) begin n_err++; $display("FAIL mask_out: got %h want 0f", mask_o[0]); end
  endtask

  task automatic test_reset_iter();
    int saw;
    @(negedge clk);
    op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'd5; eew = 2'd3; rem = 1'b0; sgn = 1'b0;
    mask = 8'hFF; ctrl = 32'h77;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL rst_iter_valid: got %b want 0", out_valid[0]); end
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL rst_iter_in_ready: got %b want 1", in_ready[0]); end
    n_cmp++; if (res[0] !== 64'd0 || mask_o[0] !== 8'd0) begin n_err++; $display("FAIL rst_iter_res: got %h/%h want 0/0", res[0], mask_o[0]); end
    saw = 0;
    repeat (80) begin @(negedge clk); if (out_valid[0]) saw = 1; end
    n_cmp++; if (saw !== 0) begin n_err++; $display("FAIL rst_iter_discard: got valid %0d want 0", saw); end
  endtask

  task automatic test_random();
    logic [63:0] got, a, b, exp, mn; logic [1:0] e; logic r, s; logic [7:0] mk;
    logic [31:0] c; int lat, sel;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 15; n++) begin
        e = 2'($urandom_range(0, 3)); r = 1'($urandom); s = 1'($urandom);
        mk = 8'($urandom); c = $urandom;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        case (e)
          2'd0:    mn = {8{8'h80}};
          2'd1:    mn = {4{16'h8000}};
          2'd2:    mn = {2{32'h8000_0000}};
          default: mn = 64'h8000_0000_0000_0000;
        endcase
        sel = $urandom_range(0, 5);
        if (sel == 0) b = 64'd0;
        else if (sel == 1) begin a = mn; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        else if (sel == 2) b = b & 64'h0F00_0F03_000F_0301;
        exp = ref_pack(a, b, e, r, s, mk);
        run_op(k, a, b, e, r, s, mk, c, got, lat);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rand_res[%0d] e=%0d r=%0d s=%0d a=%h b=%h: got %h want %h", k, e, r, s, a, b, got, exp); end
        n_cmp++; if (mask_o[k] !== mk || ctrl_o[k] !== c) begin n_err++; $display("FAIL rand_side[%0d]: got %h/%h want %h/%h", k, mask_o[k], ctrl_o[k], mk, c); end
        n_cmp++; if (lat !== (8 << e) / (1 << k) + 2) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, (8 << e) / (1 << k) + 2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned8();
    test_signed32();
    test_special16();
    test_sew64_latency();
    test_back_to_back();
    test_mask();
    test_reset_iter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
